// File: rtl/arbiter4_rr_pkg.sv
// rtl/arbiter4_rr_pkg.sv - shared types, constants and priority-search helper for arbiter4_rr
package arbiter4_rr_pkg;

   // Requester count and the width of an index into the request vector
   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   // Arbiter FSM encoding: IDLE evaluates requests, GRANT holds one owner
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // First requester with its bit set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   // The loop runs from the farthest offset down so the nearest hit wins.
   // Returns ptr when nothing is requesting; callers qualify with |req.
   function automatic logic [IDX_W-1:0] rr_pick(
      input logic [N_REQ-1:0] req,
      input logic [IDX_W-1:0] ptr
   );
      logic [IDX_W-1:0] pick;
      logic [IDX_W-1:0] cand;
      pick = ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = ptr + IDX_W'(k);
         if (req[cand]) begin
            pick = cand;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/arbiter4_rr_grant_dec24.sv
// rtl/arbiter4_rr_grant_dec24.sv - enabled 2-to-4 one-hot decoder for the grant select lines
module grant_dec24
   import arbiter4_rr_pkg::*;
(
   input  logic [IDX_W-1:0] i_idx,
   input  logic             i_en,
   output logic [N_REQ-1:0] o_onehot
);

   // One-hot decode of the index; all zero whenever the enable is low
   always_comb begin
      o_onehot = '0;
      if (i_en) begin
         case (i_idx)
            2'd0:    o_onehot = 4'b0001;
            2'd1:    o_onehot = 4'b0010;
            2'd2:    o_onehot = 4'b0100;
            default: o_onehot = 4'b1000;
         endcase
      end
   end

endmodule

// File: rtl/arbiter4_rr.sv
// rtl/arbiter4_rr.sv - four-requester round-robin arbiter with enable and hold limit
module arbiter4_rr
   import arbiter4_rr_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CW       = 4
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld
);

   // Hold budget must fit the counter and allow at least one cycle of grant
   generate
      if (MAX_HOLD < 1 || MAX_HOLD > (1 << CW) - 1) begin : g_bad_param
         $error("arbiter4_rr: MAX_HOLD out of range for CW");
      end
   endgenerate

   localparam logic [CW-1:0] LP_MAX_HOLD = CW'(MAX_HOLD);
   localparam logic [CW-1:0] LP_CNT_ONE  = CW'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_ptr_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;

   logic             w_any_req;
   logic [IDX_W-1:0] w_pick;
   logic             w_release;
   logic             w_vld;

   // Rotating priority search and the GRANT exit test, evaluated every cycle
   always_comb begin
      w_any_req = |req;
      w_pick    = rr_pick(req, r_ptr);
      w_release = (req[r_idx] == 1'b0) || (r_cnt == LP_MAX_HOLD) || !en;
   end

   // State register plus pointer, owner index and hold counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic: grant from IDLE, hold or release from GRANT
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (en && w_any_req) begin
               w_state_nxt = ST_GRANT;
               w_idx_nxt   = w_pick;
               w_cnt_nxt   = LP_CNT_ONE;
            end
         end
         ST_GRANT: begin
            if (w_release) begin
               // The owner drops to lowest priority for the next search
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = r_idx + IDX_W'(1);
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + LP_CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs come from registered state only; no path from req or en
   always_comb begin
      w_vld   = (r_state == ST_GRANT);
      gnt_vld = w_vld;
      gnt_idx = r_idx;
   end

   grant_dec24 u_grant_dec24 (
      .i_idx    (r_idx),
      .i_en     (w_vld),
      .o_onehot (gnt)
   );

endmodule

// File: tb/tb_arbiter4_rr.sv
// tb/tb_arbiter4_rr.sv - randomized and directed self-checking bench for arbiter4_rr
module tb_arbiter4_rr;

   localparam int MAX_HOLD = 8;
   localparam int CW       = 4;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;

   int n_err;
   int n_chk;

   // Reference model: who owns the slot (-1 = nobody), how long, and whose turn is next
   int m_owner;
   int m_held;
   int m_next;

   arbiter4_rr #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_next  = 0;
   endtask

   // One clock of the arbitration rules, using the inputs as they stand before the edge
   task automatic model_step();
      if (rst) begin
         model_reset();
      end else if (m_owner < 0) begin
         if (en && req != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
               if (m_owner < 0 && req[(m_next + k) % 4]) m_owner = (m_next + k) % 4;
            end
            m_held = 1;
         end
      end else if (!req[m_owner] || m_held == MAX_HOLD || !en) begin
         m_next  = (m_owner + 1) % 4;
         m_owner = -1;
         m_held  = 0;
      end else begin
         m_held++;
      end
   endtask

   task automatic compare(input string tag);
      check({tag, ".vld"}, int'(gnt_vld), (m_owner >= 0) ? 1 : 0);
      check({tag, ".gnt"}, int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
      if (m_owner >= 0) check({tag, ".idx"}, int'(gnt_idx), m_owner);
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      compare(tag);
   endtask

   // Synchronous-looking reset entry used between directed scenarios
   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Assert reset between edges and confirm outputs clear with no clock edge
   task automatic async_reset(input string tag);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check({tag, ".async_gnt"}, int'(gnt), 0);
      check({tag, ".async_vld"}, int'(gnt_vld), 0);
      check({tag, ".async_idx"}, int'(gnt_idx), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   int vld_cycles;
   int starts[$];
   logic prev_vld;

   initial begin
      n_err = 0;
      n_chk = 0;
      rst   = 1'b1;
      en    = 1'b0;
      req   = 4'b0000;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset.gnt", int'(gnt), 0);
      check("reset.vld", int'(gnt_vld), 0);
      check("reset.idx", int'(gnt_idx), 0);
      rst = 1'b0;

      // Single requester held for three cycles, then withdrawn
      en  = 1'b1;
      req = 4'b0100;
      tick("single");
      check("single.first_gnt", int'(gnt), 4);
      check("single.first_idx", int'(gnt_idx), 2);
      tick("single");
      tick("single");
      req = 4'b0000;
      tick("single");
      check("single.release", int'(gnt), 0);
      // Pointer now at 3: with 0 and 3 requesting, 3 must win
      req = 4'b1001;
      tick("single_ptr");
      check("single.ptr3", int'(gnt_idx), 3);
      req = 4'b0000;
      tick("single_ptr");

      // Full contention: order 0,1,2,3,0 with MAX_HOLD-cycle grants and one idle between
      do_reset();
      req = 4'b1111;
      vld_cycles = 0;
      prev_vld = 1'b0;
      starts.delete();
      for (int c = 0; c < 4 * (MAX_HOLD + 1) + 1; c++) begin
         tick("contend");
         if (gnt_vld) vld_cycles++;
         if (gnt_vld && !prev_vld) starts.push_back(int'(gnt_idx));
         prev_vld = gnt_vld;
      end
      check("contend.vld_cycles", vld_cycles, 4 * MAX_HOLD + 1);
      check("contend.n_grants", starts.size(), 5);
      for (int g = 0; g < starts.size() && g < 5; g++) check("contend.order", starts[g], g % 4);

      // Fairness: release requester 1, then 1 and 3 request; 3 goes first
      do_reset();
      req = 4'b0010;
      tick("fair");
      tick("fair");
      req = 4'b0000;
      tick("fair");
      req = 4'b1010;
      tick("fair");
      check("fair.first", int'(gnt_idx), 3);
      for (int c = 0; c < MAX_HOLD + 1; c++) tick("fair");
      check("fair.second", int'(gnt_idx), 1);
      req = 4'b0000;
      tick("fair");

      // Enable drop mid-grant with requesters 0 and 1 active
      do_reset();
      req = 4'b0011;
      tick("endrop");
      tick("endrop");
      tick("endrop");
      en = 1'b0;
      tick("endrop");
      check("endrop.released", int'(gnt), 0);
      tick("endrop");
      check("endrop.no_grant", int'(gnt_vld), 0);
      en = 1'b1;
      tick("endrop");
      check("endrop.next", int'(gnt), 2);
      req = 4'b0000;
      tick("endrop");

      // Asynchronous reset while requester 3 holds the slot
      do_reset();
      req = 4'b1000;
      tick("areset");
      tick("areset");
      check("areset.pre", int'(gnt), 8);
      async_reset("areset");
      req = 4'b1111;
      tick("areset");
      check("areset.after", int'(gnt), 1);

      // Randomized traffic against the model, with occasional enable drops and resets
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(3) == 0) req = 4'($urandom_range(15));
         en = ($urandom_range(9) != 0);
         if ($urandom_range(249) == 0) async_reset("rand");
         tick("rand");
         check("rand.onehot", int'($countones(gnt)), gnt_vld ? 1 : 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
